// File: rtl/mem_responder_if.sv
// mem_responder_if: req/wr/rdy memory bus between an initiator (master) and the responder (slave)
interface mem_responder_if #(parameter int DW = 64);
   logic          req;
   logic          wr;
   logic [63:0]   addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          rdy;
   logic          err;
   logic [31:0]   rd_cnt;
   logic [31:0]   wr_cnt;
   modport master (output req, wr, addr, wdata, input rdata, rdy, err, rd_cnt, wr_cnt);
   modport slave  (input req, wr, addr, wdata, output rdata, rdy, err, rd_cnt, wr_cnt);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with fixed read/write latency and access counters
module mem_responder #(
   parameter int AW     = 13,
   parameter int DW     = 64,
   parameter int RD_LAT = 2,
   parameter int WR_LAT = 5
) (
   input logic            clk,
   input logic            rst,
   mem_responder_if.slave bus
);
   localparam logic [3:0] RD_L = 4'(RD_LAT - 1);
   localparam logic [3:0] WR_L = 4'(WR_LAT - 1);
   typedef enum logic [1:0] {IDLE, BUSY, ACK, REL} state_t;
   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic          range_q, range_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          rdy_q, rdy_d;
   logic          err_q, err_d;
   logic [31:0]   rd_cnt_q, rd_cnt_d;
   logic [31:0]   wr_cnt_q, wr_cnt_d;
   logic          done;
   logic          mem_we;
   logic [DW-1:0] mem [2**AW];
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      range_d  = range_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rdy_d    = 1'b0;
      err_d    = 1'b0;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      done     = 1'b0;
      mem_we   = 1'b0;
      case (state_q)
         IDLE: if (bus.req) begin
            wr_d    = bus.wr;
            addr_d  = bus.addr[AW-1:0];
            wdata_d = bus.wdata;
            range_d = bus.addr[63:AW] == '0;
            cnt_d   = bus.wr ? WR_L : RD_L;
            state_d = BUSY;
         end
         // counter is tested before decrementing so ACK lands exactly LAT edges after capture
         BUSY: if (cnt_q == 4'd0) begin
            done    = 1'b1;
            state_d = ACK;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         ACK: state_d = REL;
         REL: state_d = bus.req ? REL : IDLE;
         default: state_d = IDLE;
      endcase
      if (done) begin
         rdy_d  = 1'b1;
         err_d  = ~range_q;
         mem_we = wr_q & range_q;
         if (wr_q) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
         end else begin
            rd_cnt_d = rd_cnt_q + 32'd1;
            rdata_d  = range_q ? mem[addr_q] : '0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wr_q     <= 1'b0;
         range_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rdy_q    <= 1'b0;
         err_q    <= 1'b0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_q     <= wr_d;
         range_q  <= range_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rdy_q    <= rdy_d;
         err_q    <= err_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end
   // array is never reset; reset only suppresses a commit on the same edge
   always_ff @(posedge clk) begin
      if (rst && mem_we) mem[addr_q] <= wdata_q;
   end
   assign bus.rdata  = rdata_q;
   assign bus.rdy    = rdy_q;
   assign bus.err    = err_q;
   assign bus.rd_cnt = rd_cnt_q;
   assign bus.wr_cnt = wr_cnt_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed accesses checked by a queue scoreboard against an array model
module tb_mem_responder;
   typedef struct {
      int          due;
      bit          err;
      logic [63:0] rdata;
      logic [31:0] rc;
      logic [31:0] wc;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   logic [63:0] mem_m [8192];
   bit          known [8192];
   logic [63:0] last_m = '0;
   logic [31:0] rc_m = '0;
   logic [31:0] wc_m = '0;
   mem_responder_if #(.DW(64)) bus ();
   mem_responder #(.AW(13), .DW(64), .RD_LAT(2), .WR_LAT(5)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, act, req);
      end
   endtask
   always @(negedge clk) begin
      if (rst && bus.rdy) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rdy actual=1 required=0 at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rdy_latency", 64'(cyc), 64'(e.due));
            chk("err", 64'(bus.err), 64'(e.err));
            chk("rdata", bus.rdata, e.rdata);
            chk("rd_cnt", 64'(bus.rd_cnt), 64'(e.rc));
            chk("wr_cnt", 64'(bus.wr_cnt), 64'(e.wc));
         end
      end
   end
   task automatic access(input bit w, input logic [63:0] a, input logic [63:0] d, input int hold, input bit early);
      exp_t e;
      bit   inr;
      bit   got;
      @(negedge clk);
      bus.req = 1'b1;
      bus.wr = w;
      bus.addr = a;
      bus.wdata = d;
      inr = a[63:13] == '0;
      if (w) begin
         wc_m++;
         if (inr) begin
            mem_m[a[12:0]] = d;
            known[a[12:0]] = 1'b1;
         end
      end else begin
         rc_m++;
         last_m = inr ? mem_m[a[12:0]] : 64'd0;
      end
      e.due = cyc + 1 + (w ? 5 : 2);
      e.err = !inr;
      e.rdata = last_m;
      e.rc = rc_m;
      e.wc = wc_m;
      sb.push_back(e);
      @(negedge clk);
      bus.addr = {32'($urandom), 32'($urandom)};
      bus.wdata = {32'($urandom), 32'($urandom)};
      bus.wr = 1'($urandom);
      if (early) bus.req = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.rdy) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL rdy_timeout actual=none required=rdy addr=%0h", a);
         if (sb.size() != 0) void'(sb.pop_back());
      end
      if (!early) repeat (hold) @(negedge clk);
      bus.req = 1'b0;
      if (early || hold == 0) @(negedge clk);
   endtask
   initial begin
      bit          w;
      logic [63:0] a;
      bus.req = 1'b0;
      bus.wr = 1'b0;
      bus.addr = '0;
      bus.wdata = '0;
      for (int i = 0; i < 8192; i++) known[i] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      chk("reset_rdy", 64'(bus.rdy), 64'd0);
      chk("reset_err", 64'(bus.err), 64'd0);
      chk("reset_rdata", bus.rdata, 64'd0);
      chk("reset_rd_cnt", 64'(bus.rd_cnt), 64'd0);
      chk("reset_wr_cnt", 64'(bus.wr_cnt), 64'd0);
      access(1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, 0, 1'b0);
      access(1'b0, 64'h10, 64'h0, 0, 1'b0);
      access(1'b1, 64'h1FFF, 64'd7, 0, 1'b0);
      access(1'b0, 64'h1FFF, 64'h0, 0, 1'b0);
      access(1'b1, 64'h1FFF, last_m + 64'd1, 0, 1'b0);
      access(1'b0, 64'h1FFF, 64'h0, 0, 1'b0);
      access(1'b1, 64'h0, 64'h1234, 0, 1'b0);
      access(1'b1, 64'h2000, 64'h55, 0, 1'b0);
      access(1'b0, 64'h2000, 64'h0, 0, 1'b0);
      access(1'b0, 64'h0, 64'h0, 0, 1'b0);
      access(1'b0, 64'h10, 64'h0, 4, 1'b0);
      access(1'b0, 64'h1FFF, 64'h0, 1, 1'b0);
      access(1'b1, 64'h3, 64'd9, 0, 1'b1);
      access(1'b0, 64'h3, 64'h0, 0, 1'b0);
      access(1'b1, 64'h4, 64'd1, 0, 1'b0);
      @(negedge clk);
      bus.req = 1'b1;
      bus.wr = 1'b1;
      bus.addr = 64'h4;
      bus.wdata = 64'hAA;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      bus.req = 1'b0;
      rc_m = '0;
      wc_m = '0;
      last_m = '0;
      chk("midrst_rdy", 64'(bus.rdy), 64'd0);
      chk("midrst_rd_cnt", 64'(bus.rd_cnt), 64'd0);
      chk("midrst_wr_cnt", 64'(bus.wr_cnt), 64'd0);
      chk("midrst_rdata", bus.rdata, 64'd0);
      repeat (8) @(negedge clk);
      access(1'b0, 64'h4, 64'h0, 0, 1'b0);
      for (int n = 0; n < 80; n++) begin
         w = 1'($urandom);
         if ($urandom_range(0, 9) == 0) a = {32'($urandom), 32'($urandom)} | 64'h2000;
         else if ($urandom_range(0, 1) == 1) a = 64'($urandom_range(0, 15));
         else a = 64'($urandom_range(8180, 8191));
         if (!w && a[63:13] == '0 && !known[a[12:0]]) w = 1'b1;
         access(w, a, {32'($urandom), 32'($urandom)}, int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
      end
      repeat (10) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
